// File: rtl/clock_timekeeper_pkg.sv
// Shared limits and field widths for the hours/minutes/seconds timekeeper.
// Field widths hold the largest in-range value of each time field.
package clock_timekeeper_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef logic [5:0] sec_t;
  typedef logic [5:0] min_t;
  typedef logic [4:0] hour_t;

endpackage

// File: rtl/clock_timekeeper_mod_counter.sv
// Modulo-(MAX+1) counter with synchronous load; carry is combinational and flags a wrap on this edge.
// Latency: count updates one edge after inc/load; load wins over inc; no backpressure.
module mod_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         carry
);

  assign carry = inc && (count == W'(MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= carry ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// 24-hour timekeeper: prescaler yields a seconds tick feeding cascaded 60/60/24 counters, with validated preset.
// Latency: all outputs registered, one edge after the cause; free-running, no backpressure.
module clock_timekeeper
  import clock_timekeeper_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       LOAD,
  input  logic [4:0] LD_HOUR,
  input  logic [5:0] LD_MIN,
  input  logic [5:0] LD_SEC,
  output logic [4:0] HOUR,
  output logic [5:0] MIN,
  output logic [5:0] SEC,
  output logic       TICK,
  output logic       DAY_WRAP,
  output logic       LOAD_ERR
);

  localparam int PRESC_W = $clog2(TICKS_PER_SEC);

  logic [PRESC_W-1:0] presc;
  logic               tick_int;
  logic               ld_ok;
  logic               do_load;
  logic               sec_carry;
  logic               min_carry;
  logic               hour_carry;

  assign tick_int = EN && (presc == PRESC_W'(TICKS_PER_SEC - 1));
  assign ld_ok    = (LD_HOUR <= hour_t'(HOUR_MAX)) &&
                    (LD_MIN  <= min_t'(MIN_MAX))   &&
                    (LD_SEC  <= sec_t'(SEC_MAX));
  // A rejected load leaves counting untouched, including a coincident tick.
  assign do_load  = LOAD && ld_ok;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc    <= '0;
      TICK     <= 1'b0;
      DAY_WRAP <= 1'b0;
      LOAD_ERR <= 1'b0;
    end else begin
      if (do_load) begin
        presc <= '0;
      end else if (EN) begin
        presc <= tick_int ? '0 : presc + 1'b1;
      end
      TICK     <= tick_int && !do_load;
      DAY_WRAP <= hour_carry && !do_load;
      LOAD_ERR <= LOAD && !ld_ok;
    end
  end

  mod_counter #(.W($bits(sec_t)), .MAX(SEC_MAX)) u_sec (
    .clk      (CLK),
    .rst_n    (RST_N),
    .inc      (tick_int),
    .load     (do_load),
    .load_val (LD_SEC),
    .count    (SEC),
    .carry    (sec_carry)
  );

  mod_counter #(.W($bits(min_t)), .MAX(MIN_MAX)) u_min (
    .clk      (CLK),
    .rst_n    (RST_N),
    .inc      (sec_carry),
    .load     (do_load),
    .load_val (LD_MIN),
    .count    (MIN),
    .carry    (min_carry)
  );

  mod_counter #(.W($bits(hour_t)), .MAX(HOUR_MAX)) u_hour (
    .clk      (CLK),
    .rst_n    (RST_N),
    .inc      (min_carry),
    .load     (do_load),
    .load_val (LD_HOUR),
    .count    (HOUR),
    .carry    (hour_carry)
  );

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper with a 4-cycle second: vector table, corner sequences, random run vs model.
module tb_clock_timekeeper;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [4:0] ld_hour = '0;
  logic [5:0] ld_min = '0;
  logic [5:0] ld_sec = '0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       tick;
  logic       day_wrap;
  logic       load_err;

  int tests = 0;
  int fails = 0;

  // Reference: time kept as seconds-of-day plus a phase within the current second.
  int m_secs = 0;
  int m_phase = 0;
  bit m_tick = 0, m_dw = 0, m_err = 0;

  always #5 clk = ~clk;

  clock_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .EN       (en),
    .LOAD     (load),
    .LD_HOUR  (ld_hour),
    .LD_MIN   (ld_min),
    .LD_SEC   (ld_sec),
    .HOUR     (hour),
    .MIN      (min),
    .SEC      (sec),
    .TICK     (tick),
    .DAY_WRAP (day_wrap),
    .LOAD_ERR (load_err)
  );

  typedef struct {
    bit r, e, l;
    int h, m, s;
    int eh, em, es;
    bit et, ed, ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit l, int h, int m, int s,
                              int eh, int em, int es, bit et, bit ed, bit ee);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.h = h; v.m = m; v.s = s;
    v.eh = eh; v.em = em; v.es = es; v.et = et; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit l, input int h, input int m, input int s);
    if (!r) begin
      m_secs = 0; m_phase = 0; m_tick = 0; m_dw = 0; m_err = 0;
    end else if (l && h <= 23 && m <= 59 && s <= 59) begin
      m_secs = h * 3600 + m * 60 + s; m_phase = 0;
      m_tick = 0; m_dw = 0; m_err = 0;
    end else begin
      m_err = l;
      m_tick = 0; m_dw = 0;
      if (e) begin
        if (m_phase == TPS - 1) begin
          m_phase = 0;
          m_secs = (m_secs + 1) % 86400;
          m_tick = 1;
          m_dw = (m_secs == 0);
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end
  endtask

  task automatic check_vals(input string name, input int eh, input int em, input int es,
                            input bit et, input bit ed, input bit ee);
    tests++;
    if (int'(hour) != eh || int'(min) != em || int'(sec) != es ||
        tick !== et || day_wrap !== ed || load_err !== ee) begin
      fails++;
      $display("FAIL %s @%0t: got %0d:%0d:%0d tick=%0b wrap=%0b err=%0b, want %0d:%0d:%0d tick=%0b wrap=%0b err=%0b",
               name, $time, hour, min, sec, tick, day_wrap, load_err, eh, em, es, et, ed, ee);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int h, input int m, input int s);
    rst_n = r; en = e; load = l;
    ld_hour = 5'(h); ld_min = 6'(m); ld_sec = 6'(s);
    @(posedge clk);
    model_step(r, e, l, h, m, s);
    #1;
    check_vals("model", m_secs / 3600, (m_secs / 60) % 60, m_secs % 60, m_tick, m_dw, m_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset (overriding a load), first tick, day wrap, bad/good loads, EN hold, load vs tick.
    tbl.push_back(mk(0,1,1,  5, 5, 5,   0, 0, 0, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,   0, 0, 0, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,   0, 0, 0, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,   0, 0, 0, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,   0, 0, 1, 1,0,0));
    tbl.push_back(mk(1,1,1, 23,59,59,  23,59,59, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  23,59,59, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  23,59,59, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  23,59,59, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,   0, 0, 0, 1,1,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,   0, 0, 0, 0,0,0));
    tbl.push_back(mk(1,1,1,  0,60, 0,   0, 0, 0, 0,0,1));
    tbl.push_back(mk(1,1,0,  0, 0, 0,   0, 0, 0, 0,0,0));
    tbl.push_back(mk(1,1,1, 24, 0, 0,   0, 0, 1, 1,0,1));
    tbl.push_back(mk(1,1,1, 12,34,56,  12,34,56, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,56, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,56, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,56, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,57, 1,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,57, 0,0,0));
    tbl.push_back(mk(1,0,0,  0, 0, 0,  12,34,57, 0,0,0));
    tbl.push_back(mk(1,0,0,  0, 0, 0,  12,34,57, 0,0,0));
    tbl.push_back(mk(1,0,0,  0, 0, 0,  12,34,57, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,57, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,57, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,58, 1,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,58, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,58, 0,0,0));
    tbl.push_back(mk(1,1,0,  0, 0, 0,  12,34,58, 0,0,0));
    tbl.push_back(mk(1,1,1,  1, 2, 3,   1, 2, 3, 0,0,0));
    tbl.push_back(mk(1,0,1, 10,20,30,  10,20,30, 0,0,0));
    tbl.push_back(mk(1,0,1, 10,20,60,  10,20,30, 0,0,1));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].h, tbl[i].m, tbl[i].s);
      check_vals($sformatf("vec%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es,
                 tbl[i].et, tbl[i].ed, tbl[i].ee);
    end

    // Seconds carry into minutes on the same edge.
    step(1, 1, 1, 0, 0, 58);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
    check_vals("sec59", 0, 0, 59, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
    check_vals("min_carry", 0, 1, 0, 1, 0, 0);

    // Freeze two cycles into a second; resumption needs the remaining two cycles.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
    check_vals("en_hold", 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check_vals("resume1", 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check_vals("resume2", 0, 1, 1, 1, 0, 0);

    // Mid-count reset wins over a simultaneous load.
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 5, 5, 5);
    check_vals("rst_vs_load", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0);
    check_vals("sec5_after20", 0, 0, 5, 1, 0, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, l;
      int h, m, s;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 0) begin
        h = 23; m = 59; s = $urandom_range(50, 59);
      end else begin
        h = $urandom_range(0, 31); m = $urandom_range(0, 63); s = $urandom_range(0, 63);
      end
      step(r, e, l, h, m, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
